// File: rtl/ascon_decrypt_pkg.sv
// Types, constants and small helpers shared by the Ascon-128 decryption core.
package ascon_decrypt_pkg;

    typedef logic [63:0]  u64_t;
    typedef logic [127:0] u128_t;

    typedef struct packed {
        u64_t x0;
        u64_t x1;
        u64_t x2;
        u64_t x3;
        u64_t x4;
    } ascon_state_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AD_WAIT,
        AD_PERM,
        CT_WAIT,
        CT_PERM,
        FINAL,
        DONE
    } dec_fsm_t;

    localparam u64_t ASCON128_IV   = 64'h80400c0600000000;
    localparam u64_t DOM_SEP_CONST = 64'h0000000000000001;
    localparam u64_t PAD_CONST     = 64'h80 << 56;

    // 5-bit S-box, input/output bit 4 is the x0 lane.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [7:0] rnd_const(input logic [3:0] rnd);
        return {4'(4'hf - rnd), rnd};
    endfunction

    function automatic u64_t ror(input u64_t x, input int unsigned n);
        return (x >> n) | (x << (32'd64 - n));
    endfunction

    // Padding block of an empty final CT block plus the finalization key load.
    function automatic ascon_state_t absorb_final(input ascon_state_t s, input u128_t key);
        ascon_state_t o;
        o    = s;
        o.x0 = s.x0 ^ PAD_CONST;
        o.x1 = s.x1 ^ key[127:64];
        o.x2 = s.x2 ^ key[63:0];
        return o;
    endfunction

    // Domain separation into the CT phase; an empty CT phase finalizes at once.
    function automatic ascon_state_t enter_ct(input ascon_state_t s, input u128_t key,
                                              input logic ct_empty);
        ascon_state_t o;
        o    = s;
        o.x4 = s.x4 ^ DOM_SEP_CONST;
        if (ct_empty) begin
            o = absorb_final(o, key);
        end
        return o;
    endfunction

endpackage

// File: rtl/ascon_decrypt_round.sv
// One combinational Ascon permutation round: constant add, S-box layer, linear layer.
module ascon_decrypt_round
    import ascon_decrypt_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [7:0]   rc,
    output ascon_state_t state_out
);

    ascon_state_t c;
    ascon_state_t s;
    logic [4:0]   col;

    always_comb begin
        c    = state_in;
        c.x2 = state_in.x2 ^ {56'h0, rc};
        s    = c;
        col  = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            col      = SBOX[{c.x0[i], c.x1[i], c.x2[i], c.x3[i], c.x4[i]}];
            s.x0[i]  = col[4];
            s.x1[i]  = col[3];
            s.x2[i]  = col[2];
            s.x3[i]  = col[1];
            s.x4[i]  = col[0];
        end
    end

    always_comb begin
        state_out.x0 = s.x0 ^ ror(s.x0, 19) ^ ror(s.x0, 28);
        state_out.x1 = s.x1 ^ ror(s.x1, 61) ^ ror(s.x1, 39);
        state_out.x2 = s.x2 ^ ror(s.x2, 1)  ^ ror(s.x2, 6);
        state_out.x3 = s.x3 ^ ror(s.x3, 10) ^ ror(s.x3, 17);
        state_out.x4 = s.x4 ^ ror(s.x4, 7)  ^ ror(s.x4, 41);
    end

endmodule

// File: rtl/ascon_decrypt.sv
// Ascon-128 decryption core: one permutation round per cycle, 64-bit block stream in,
// plaintext out, tag verdict at the end.
module ascon_decrypt
    import ascon_decrypt_pkg::*;
#(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          ad_empty_i,
    input  logic          ct_empty_i,
    input  logic [127:0]  key_i,
    input  logic [127:0]  nonce_i,
    input  logic [127:0]  tag_i,
    input  logic [63:0]   blk_i,
    input  logic          blk_valid_i,
    input  logic          blk_last_i,
    output logic          blk_ready_o,
    output logic [63:0]   pt_o,
    output logic          pt_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          tag_ok_o
);

    localparam logic [3:0] LOAD_A   = 4'(12 - ROUNDS_A);
    localparam logic [3:0] LOAD_B   = 4'(12 - ROUNDS_B);
    localparam logic [3:0] RND_LAST = 4'd11;

    dec_fsm_t     state;
    ascon_state_t s;
    ascon_state_t r;
    ascon_state_t init_fin;
    ascon_state_t ct_from_init;
    ascon_state_t ct_from_ad;
    logic [3:0]   rnd;
    logic [7:0]   rc;
    logic         blk_last;
    logic         ad_pad;
    logic         ad_empty;
    logic         ct_empty;
    logic         accept;
    logic         last_round;
    u128_t        tag;

    assign rc = rnd_const(rnd);

    ascon_decrypt_round u_round (
        .state_in  (s),
        .rc        (rc),
        .state_out (r)
    );

    assign last_round  = (rnd == RND_LAST);
    assign blk_ready_o = (state == AD_WAIT) || (state == CT_WAIT);
    assign accept      = blk_valid_i && blk_ready_o;
    assign pt_valid_o  = (state == CT_WAIT) && blk_valid_i;
    assign pt_o        = pt_valid_o ? (s.x0 ^ blk_i) : '0;
    assign busy_o      = (state != IDLE);
    assign tag         = {r.x3, r.x4} ^ key_i;

    // Candidate states for the phase transitions that happen on a terminal round.
    always_comb begin
        init_fin     = r;
        init_fin.x3  = r.x3 ^ key_i[127:64];
        init_fin.x4  = r.x4 ^ key_i[63:0];
        ct_from_init = enter_ct(init_fin, key_i, ct_empty);
        ct_from_ad   = enter_ct(r, key_i, ct_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            rnd      <= '0;
            blk_last <= 1'b0;
            ad_pad   <= 1'b0;
            ad_empty <= 1'b0;
            ct_empty <= 1'b0;
            done_o   <= 1'b0;
            tag_ok_o <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            tag_ok_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        s        <= {ASCON128_IV, key_i, nonce_i};
                        rnd      <= LOAD_A;
                        ad_empty <= ad_empty_i;
                        ct_empty <= ct_empty_i;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    s   <= r;
                    rnd <= rnd + 4'd1;
                    if (last_round) begin
                        if (ad_empty) begin
                            s     <= ct_from_init;
                            rnd   <= LOAD_A;
                            state <= ct_empty ? FINAL : CT_WAIT;
                        end else begin
                            s     <= init_fin;
                            state <= AD_WAIT;
                        end
                    end
                end
                AD_WAIT: begin
                    if (accept) begin
                        s.x0     <= s.x0 ^ blk_i;
                        rnd      <= LOAD_B;
                        blk_last <= blk_last_i;
                        ad_pad   <= 1'b0;
                        state    <= AD_PERM;
                    end
                end
                AD_PERM: begin
                    s   <= r;
                    rnd <= rnd + 4'd1;
                    if (last_round) begin
                        if (ad_pad) begin
                            s     <= ct_from_ad;
                            rnd   <= LOAD_A;
                            state <= ct_empty ? FINAL : CT_WAIT;
                        end else if (blk_last) begin
                            // Full-block AD is followed by a separate padding block.
                            s.x0   <= r.x0 ^ PAD_CONST;
                            rnd    <= LOAD_B;
                            ad_pad <= 1'b1;
                        end else begin
                            state <= AD_WAIT;
                        end
                    end
                end
                CT_WAIT: begin
                    if (accept) begin
                        s.x0     <= blk_i;
                        rnd      <= LOAD_B;
                        blk_last <= blk_last_i;
                        state    <= CT_PERM;
                    end
                end
                CT_PERM: begin
                    s   <= r;
                    rnd <= rnd + 4'd1;
                    if (last_round) begin
                        if (blk_last) begin
                            s     <= absorb_final(r, key_i);
                            rnd   <= LOAD_A;
                            state <= FINAL;
                        end else begin
                            state <= CT_WAIT;
                        end
                    end
                end
                FINAL: begin
                    s   <= r;
                    rnd <= rnd + 4'd1;
                    if (last_round) begin
                        done_o   <= 1'b1;
                        tag_ok_o <= (tag == tag_i);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_decrypt.sv
// Bench for ascon_decrypt: an Ascon-128 encryption model produces ciphertext and tags,
// a negedge monitor checks plaintext, strobes and tag verdicts against it.
module tb_ascon_decrypt;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          ad_empty_i;
    logic          ct_empty_i;
    logic [127:0]  key_i;
    logic [127:0]  nonce_i;
    logic [127:0]  tag_i;
    logic [63:0]   blk_i;
    logic          blk_valid_i;
    logic          blk_last_i;
    logic          blk_ready_o;
    logic [63:0]   pt_o;
    logic          pt_valid_o;
    logic          busy_o;
    logic          done_o;
    logic          tag_ok_o;

    ascon_decrypt dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .ad_empty_i  (ad_empty_i),
        .ct_empty_i  (ct_empty_i),
        .key_i       (key_i),
        .nonce_i     (nonce_i),
        .tag_i       (tag_i),
        .blk_i       (blk_i),
        .blk_valid_i (blk_valid_i),
        .blk_last_i  (blk_last_i),
        .blk_ready_o (blk_ready_o),
        .pt_o        (pt_o),
        .pt_valid_o  (pt_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tag_ok_o    (tag_ok_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int exp_acc = 0;
    bit done_seen = 1'b0;
    bit exp_tag_ok = 1'b0;
    logic [63:0] exp_q [$];

    localparam logic [127:0] K1      = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
    localparam logic [127:0] K2      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] N2      = 128'h13579bdf02468ace1122334455667788;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- Ascon-128 reference (word-level, encryption direction) --------
    logic [63:0] m [5];
    logic [63:0] ad_v [8];
    logic [63:0] pt_v [8];
    logic [63:0] ct_v [8];

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic m_round(input int i);
        logic [63:0] t [5];
        m[2] = m[2] ^ 64'((15 - i) * 16 + i);
        m[0] = m[0] ^ m[4];
        m[4] = m[4] ^ m[3];
        m[2] = m[2] ^ m[1];
        for (int k = 0; k < 5; k++) t[k] = ~m[k] & m[(k + 1) % 5];
        for (int k = 0; k < 5; k++) m[k] = m[k] ^ t[(k + 1) % 5];
        m[1] = m[1] ^ m[0];
        m[0] = m[0] ^ m[4];
        m[3] = m[3] ^ m[2];
        m[2] = ~m[2];
        m[0] = m[0] ^ rr(m[0], 19) ^ rr(m[0], 28);
        m[1] = m[1] ^ rr(m[1], 61) ^ rr(m[1], 39);
        m[2] = m[2] ^ rr(m[2], 1)  ^ rr(m[2], 6);
        m[3] = m[3] ^ rr(m[3], 10) ^ rr(m[3], 17);
        m[4] = m[4] ^ rr(m[4], 7)  ^ rr(m[4], 41);
    endtask

    task automatic m_perm(input int nr);
        for (int i = 12 - nr; i < 12; i++) m_round(i);
    endtask

    task automatic model_encrypt(input logic [127:0] k, input logic [127:0] n,
                                 input int na, input int np, output logic [127:0] tag);
        m[0] = 64'h80400c0600000000;
        m[1] = k[127:64];
        m[2] = k[63:0];
        m[3] = n[127:64];
        m[4] = n[63:0];
        m_perm(12);
        m[3] = m[3] ^ k[127:64];
        m[4] = m[4] ^ k[63:0];
        if (na > 0) begin
            for (int i = 0; i < na; i++) begin
                m[0] = m[0] ^ ad_v[i];
                m_perm(6);
            end
            m[0] = m[0] ^ 64'h8000000000000000;
            m_perm(6);
        end
        m[4] = m[4] ^ 64'h1;
        for (int i = 0; i < np; i++) begin
            m[0] = m[0] ^ pt_v[i];
            ct_v[i] = m[0];
            m_perm(6);
        end
        m[0] = m[0] ^ 64'h8000000000000000;
        m[1] = m[1] ^ k[127:64];
        m[2] = m[2] ^ k[63:0];
        m_perm(12);
        tag = {m[3] ^ k[127:64], m[4] ^ k[63:0]};
    endtask

    task automatic fill_data(input logic [63:0] seed);
        for (int i = 0; i < 8; i++) begin
            ad_v[i] = (seed * 64'(i + 3)) ^ 64'ha5a5a5a5_00000000;
            pt_v[i] = (seed + 64'(i)) * 64'h9e3779b97f4a7c15;
        end
    endtask

    // ---------------- Monitor: every cycle outside reset ----------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (pt_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pt_extra: got strobe with pt %h, expected none", pt_o);
                end else begin
                    chk("pt", 128'(pt_o), 128'(exp_q.pop_front()));
                end
            end else begin
                chk("pt_zero", 128'(pt_o), 128'h0);
            end
            if (blk_valid_i && blk_ready_o) acc_cnt++;
            if (done_o) begin
                chk("tag_ok", 128'(tag_ok_o), 128'(exp_tag_ok));
                chk("accepts", 128'(acc_cnt), 128'(exp_acc));
                done_cyc  = cyc;
                done_seen = 1'b1;
            end else begin
                chk("tag_ok_idle", 128'(tag_ok_o), 128'h0);
            end
        end
    end

    // ---------------- Drivers --------------------------------------------------------
    task automatic send_blk(input logic [63:0] d, input logic l, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                blk_valid_i = 1'b0;
                blk_i       = {$urandom, $urandom};
                @(posedge clk);
                #1;
            end
        end
        blk_i       = d;
        blk_valid_i = 1'b1;
        blk_last_i  = gaps ? 1'($urandom) : l;
        t = 0;
        forever begin
            @(negedge clk);
            if (blk_ready_o) break;
            t++;
            if (t > 100) begin
                fail_msg("blk_ready_wait");
                break;
            end
            if (gaps) blk_last_i = 1'($urandom);
        end
        blk_last_i = l;
        @(posedge clk);
        #1;
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
    endtask

    task automatic start_op(input logic [127:0] k, input logic [127:0] n, input int na,
                            input int np, input logic [127:0] tg, input bit ok);
        exp_q.delete();
        for (int i = 0; i < np; i++) exp_q.push_back(pt_v[i]);
        exp_tag_ok = ok;
        exp_acc    = na + np;
        acc_cnt    = 0;
        done_seen  = 1'b0;
        key_i      = k;
        nonce_i    = n;
        tag_i      = tg;
        ad_empty_i = (na == 0);
        ct_empty_i = (np == 0);
        start_cyc  = cyc;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", 128'(busy_o), 128'h1);
        chk("ready_in_init", 128'(blk_ready_o), 128'h0);
    endtask

    task automatic run_op(input logic [127:0] k, input logic [127:0] n, input int na,
                          input int np, input int flip, input bit gaps, input bit restart);
        logic [127:0] tg;
        int t;
        model_encrypt(k, n, na, np, tg);
        if (flip >= 0) tg = tg ^ (128'h1 << flip);
        start_op(k, n, na, np, tg, flip < 0);
        if (restart) begin
            repeat (2) begin @(posedge clk); #1; end
            start_i = 1'b1;
            nonce_i = ~n;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        for (int i = 0; i < na; i++) send_blk(ad_v[i], i == na - 1, gaps);
        for (int i = 0; i < np; i++) send_blk(ct_v[i], i == np - 1, gaps);
        t = 0;
        while (!done_seen && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (!done_seen) fail_msg("done_wait");
        if (na == 0 && np == 0) chk("latency", 128'(done_cyc - start_cyc), 128'd25);
        chk("pt_all_seen", 128'(exp_q.size()), 128'h0);
        #1;
        chk("idle_busy", 128'(busy_o), 128'h0);
        chk("idle_done", 128'(done_o), 128'h0);
    endtask

    // ---------------- Main sequence --------------------------------------------------
    initial begin
        logic [127:0] tg;
        rst = 1'b1;
        start_i = 1'b0; ad_empty_i = 1'b0; ct_empty_i = 1'b0;
        key_i = '0; nonce_i = '0; tag_i = '0;
        blk_i = '0; blk_valid_i = 1'b0; blk_last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy_o), 128'h0);
        chk("rst_done", 128'(done_o), 128'h0);
        chk("rst_ready", 128'(blk_ready_o), 128'h0);
        chk("rst_pt", {63'h0, pt_valid_o, pt_o}, 128'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Known answer: empty AD, empty CT
        model_encrypt(K1, K1, 0, 0, tg);
        chk("model_kat_tag", tg, KAT_TAG);
        run_op(K1, K1, 0, 0, -1, 1'b0, 1'b0);
        run_op(K1, K1, 0, 0, 0, 1'b0, 1'b0);

        // 2 AD + 3 CT, back-to-back, then with gaps, random last and a stray start
        fill_data(64'h0123456789abcdef);
        run_op(K2, N2, 2, 3, -1, 1'b0, 1'b0);
        run_op(K2, N2, 2, 3, -1, 1'b1, 1'b1);
        run_op(K1, N2, 3, 0, -1, 1'b1, 1'b0);
        run_op(K2, K1, 0, 2, 127, 1'b0, 1'b0);

        // Reset in the middle of a CT permutation
        fill_data(64'hfeedface00c0ffee);
        model_encrypt(K2, N2, 0, 2, tg);
        start_op(K2, N2, 0, 2, tg, 1'b1);
        send_blk(ct_v[0], 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("busy_before_rst", 128'(busy_o), 128'h1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy_o), 128'h0);
        chk("midrst_ready", 128'(blk_ready_o), 128'h0);
        chk("midrst_done", {126'h0, done_o, tag_ok_o}, 128'h0);
        chk("midrst_pt", {63'h0, pt_valid_o, pt_o}, 128'h0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_op(K2, N2, 0, 2, -1, 1'b0, 1'b0);

        fill_data(64'h5555aaaa3333cccc);
        run_op(K1, N2, 1, 1, -1, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_decrypt.md
ASCON_DECRYPT -- requirements
Module: ascon_decrypt

Interface
REQ-001 Parameter ROUNDS_A, default 12, number of rounds for initialization/finalization permutations.
REQ-002 Parameter ROUNDS_B, default 6, number of rounds per data-block permutation.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  pulse in IDLE to begin one decryption; key/nonce/flags sampled that cycle.
REQ-006 ad_empty_i  in  1  at start: no associated-data blocks follow.
REQ-007 ct_empty_i  in  1  at start: no ciphertext blocks follow.
REQ-008 key_i  in  128  secret key, held stable from start to done_o.
REQ-009 nonce_i  in  128  nonce.
REQ-010 tag_i  in  128  received tag, held stable from start to done_o.
REQ-011 blk_i  in  64  AD block or CT block (full 8 bytes, big-endian).
REQ-012 blk_valid_i / blk_last_i  in  1/1  block offered / final block of current phase.
REQ-013 blk_ready_o  out  1  block accepted when blk_valid_i && blk_ready_o.
REQ-014 pt_o / pt_valid_o  out  64/1  plaintext and its one-cycle strobe.
REQ-015 busy_o / done_o / tag_ok_o  out  1/1/1  operation active / one-cycle completion pulse / tag match (valid with done_o).

Function
REQ-016 States: IDLE, INIT, AD_WAIT, AD_PERM, CT_WAIT, CT_PERM, FINAL, DONE.
REQ-017 IDLE + start_i: state <- {Ascon128IV, K_hi, K_lo, N_hi, N_lo}; go INIT; start_i outside IDLE ignored.
REQ-018 INIT: ROUNDS_A rounds, one per cycle (rnd 12-ROUNDS_A..11); after last round x3,x4 ^= K; next AD_WAIT, or if ad_empty_i x4 ^= DomSepConst and next CT_WAIT.
REQ-019 AD_WAIT: blk_ready_o=1; on accept x0 ^= blk_i, go AD_PERM (ROUNDS_B rounds); return to AD_WAIT unless block was last.
REQ-020 After last AD block's permutation: x0 ^= PadConst (64'h80<<56), ROUNDS_B more rounds, then x4 ^= DomSepConst, go CT_WAIT.
REQ-021 CT_WAIT: blk_ready_o=1; on accept pt_o = x0 ^ blk_i and pt_valid_o=1 in the same cycle (combinational); x0 <- blk_i; go CT_PERM (ROUNDS_B rounds), back to CT_WAIT unless last.
REQ-022 After last CT block (or immediately if ct_empty_i): x0 ^= PadConst, x1 ^= K_hi, x2 ^= K_lo, go FINAL.
REQ-023 FINAL: ROUNDS_A rounds; tag' = {x3,x4} ^ K; full 128-bit compare with tag_i, no early exit.
REQ-024 DONE: one cycle, done_o=1, tag_ok_o=(tag'==tag_i); return to IDLE.
REQ-025 blk_ready_o=0 in every state except AD_WAIT/CT_WAIT; pt_o=0 when pt_valid_o=0; tag_ok_o=0 when done_o=0.
REQ-026 busy_o=1 in all states except IDLE.
REQ-027 Round counter 4 bits, loaded with 12-ROUNDS_x, terminal at 11; round constant RndConst[rnd].
REQ-028 blk_valid_i without blk_ready_o has no effect; blk_last_i ignored unless the block is accepted.
REQ-029 Latency, ad_empty_i=ct_empty_i=1: done_o asserts 2*ROUNDS_A+1 cycles after start_i cycle.

Reset
REQ-030 rst asserted: state registers, counter cleared; FSM IDLE; all outputs 0, asynchronously, including mid-operation.
REQ-031 After rst deassertion core accepts start_i on the first rising edge.

Structure
REQ-032 ascon_pack holds Ascon128IV, DomSepConst, PadConst, RndConst, Sbox, u64_t/u128_t, ascon_state_t and the dec_fsm_t state enum.
REQ-033 One combinational sub-module ascon_round (constant-add, S-box, linear layer) instantiated once; FSM, counter and XOR injection stay in ascon_decrypt.

Verification
REQ-034 Key=nonce=0x000102..0F, empty AD, empty CT, tag_i=E355159F292911F794CB1432A0103A8A -> done_o 25 cycles after start, tag_ok_o=1.
REQ-035 Same with tag_i bit 0 flipped -> done_o, tag_ok_o=0.
REQ-036 Ciphertext produced by golden model for 2 AD + 3 PT blocks -> pt_o equals original plaintext on each of 3 pt_valid_o pulses, tag_ok_o=1.
REQ-037 blk_valid_i toggled randomly with gaps, blk_valid_i held during INIT/permutations -> no extra accepts, identical pt_o/tag result.
REQ-038 rst pulsed during CT_PERM -> outputs 0 immediately, FSM IDLE; new start decrypts correctly.
REQ-039 start_i pulsed while busy_o=1 -> ignored, result unchanged.
